dp_arbiter: RTL

DP_ARBITER -- requirements
Module: dp_arbiter

---
 rtl/dp_arbiter_if.sv | 25 ++
 rtl/dp_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dp_arbiter_if.sv
// Bundle of request, grant and datapath handshake signals for dp_arbiter.
// master: arbiter side. slave: requesters and datapath controller side.
interface dp_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_mode;
   logic            dp_done;
   logic [NREQ-1:0] gnt;
   logic            dp_start;
   logic            dp_mode;
   logic [NREQ-1:0] ack;
   logic            err;
   logic            busy;

   modport master (
      input  req, req_mode, dp_done,
      output gnt, dp_start, dp_mode, ack, err, busy
   );

   modport slave (
      output req, req_mode, dp_done,
      input  gnt, dp_start, dp_mode, ack, err, busy
   );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters access to a shared datapath.
// Moore FSM IDLE -> START -> WAIT -> RELEASE, all outputs registered.
// Optional WAIT watchdog compiled in with macro DP_ARBITER_WATCHDOG_EN; without it
// WAIT is held until dp_done and err is tied low.
module dp_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input logic          clk,
   input logic          reset,
   dp_arbiter_if.master bus
);
   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StWait, StRelease} state_e;

   // Reject out-of-range configurations at elaboration.
   if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_cfg
      $error("dp_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
   end

   state_e          state_q;
   logic [IdxW-1:0] sel_q;
   logic [IdxW-1:0] last_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] ack_q;
   logic            dp_start_q;
   logic            dp_mode_q;
   logic            busy_q;
   logic [IdxW-1:0] win_idx;
   logic            win_found;
   logic [NREQ-1:0] win_onehot;

`ifdef DP_ARBITER_WATCHDOG_EN
   logic [7:0]      wd_cnt_q;
   logic            err_q;
`endif

   // Round-robin search: first set req bit starting just above the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!win_found && bus.req[IdxW'((32'(last_q) + i) % NREQ)]) begin
            win_found = 1'b1;
            win_idx   = IdxW'((32'(last_q) + i) % NREQ);
         end
      end
      win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
   end

   // Arbiter FSM with registered outputs; last starts at NREQ-1 so requester 0 wins first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         last_q     <= IdxW'(NREQ - 1);
         gnt_q      <= '0;
         ack_q      <= '0;
         dp_start_q <= 1'b0;
         dp_mode_q  <= 1'b0;
         busy_q     <= 1'b0;
`ifdef DP_ARBITER_WATCHDOG_EN
         wd_cnt_q   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         dp_start_q <= 1'b0;
         ack_q      <= '0;
`ifdef DP_ARBITER_WATCHDOG_EN
         err_q      <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  sel_q      <= win_idx;
                  gnt_q      <= win_onehot;
                  dp_mode_q  <= bus.req_mode[win_idx];
                  dp_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               // dp_done is deliberately ignored here.
               state_q <= StWait;
`ifdef DP_ARBITER_WATCHDOG_EN
               wd_cnt_q <= '0;
`endif
            end
            StWait: begin
               if (bus.dp_done) begin
                  ack_q   <= gnt_q;
                  state_q <= StRelease;
`ifdef DP_ARBITER_WATCHDOG_EN
               end else if (wd_cnt_q == 8'(TIMEOUT - 1)) begin
                  // TIMEOUT edges spent in WAIT without completion.
                  ack_q   <= gnt_q;
                  err_q   <= 1'b1;
                  state_q <= StRelease;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 8'd1;
`endif
               end
            end
            StRelease: begin
               last_q    <= sel_q;
               gnt_q     <= '0;
               dp_mode_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.ack      = ack_q;
   assign bus.dp_start = dp_start_q;
   assign bus.dp_mode  = dp_mode_q;
   assign bus.busy     = busy_q;
`ifdef DP_ARBITER_WATCHDOG_EN
   assign bus.err      = err_q;
`else
   assign bus.err      = 1'b0;
`endif
endmodule
